// File: rtl/cas_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cas_pkg
// Brief   : Shared FSM state encoding and default sizes for cas_sort_seq.
// Revision: 1.0 - initial release
// ============================================================================
package cas_pkg;

    localparam int unsigned CAS_SNG_WIDTH = 4;
    localparam int unsigned CAS_NUM_ELEM  = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } cas_state_e;

endpackage : cas_pkg
`default_nettype wire

// File: rtl/cas.sv
`default_nettype none
// ============================================================================
// Module  : cas
// Brief   : Two-input compare-and-swap; a_new_o = max, b_new_o = min.
// Revision: 1.0 - initial release
// ============================================================================
module cas #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_new_o,
    output logic [WIDTH-1:0] b_new_o,
    output logic             swap_o
);

    // Strict compare keeps equal values in place.
    assign swap_o  = (a_i < b_i);
    assign a_new_o = swap_o ? b_i : a_i;
    assign b_new_o = swap_o ? a_i : b_i;

endmodule : cas
`default_nettype wire

// File: rtl/cas_sort_seq.sv
`default_nettype none
// ============================================================================
// Module  : cas_sort_seq
// Brief   : Sequential odd-even transposition sorter (descending) built on a
//           single compare-and-swap. Optional macro CAS_SORT_EARLY_EXIT_EN
//           stops sorting after an even+odd phase pair with no swaps.
// Revision: 1.0 - initial release
// ============================================================================
module cas_sort_seq
    import cas_pkg::*;
#(
    parameter int unsigned SNG_WIDTH = CAS_SNG_WIDTH,
    parameter int unsigned NUM_ELEM  = CAS_NUM_ELEM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SNG_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SNG_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(NUM_ELEM);
    localparam int unsigned PW = IW - 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_ELEM - 1);
    localparam logic [IW-1:0] LAST_PHASE = IW'(NUM_ELEM - 1);
    localparam logic [PW-1:0] EVEN_LAST  = PW'(NUM_ELEM / 2 - 1);
    localparam logic [PW-1:0] ODD_LAST   = PW'(NUM_ELEM / 2 - 2);
`ifdef CAS_SORT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    cas_state_e           state_q, state_d;
    logic [SNG_WIDTH-1:0] mem_q [NUM_ELEM];
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        phase_q, phase_d;
    logic [PW-1:0]        pair_q, pair_d;
    logic                 swp_q, swp_d;

    logic [IW-1:0]        w_lo, w_hi;
    logic [SNG_WIDTH-1:0] w_a_new, w_b_new;
    logic                 w_swap, w_load_en, w_sort_en, w_phase_end;

    // Lower index of the current pair: even phase 2p, odd phase 2p+1.
    assign w_lo = {pair_q, phase_q[0]};
    assign w_hi = w_lo + IW'(1);

    cas #(
        .WIDTH   (SNG_WIDTH)
    ) u_cas (
        .a_i     (mem_q[w_lo]),
        .b_i     (mem_q[w_hi]),
        .a_new_o (w_a_new),
        .b_new_o (w_b_new),
        .swap_o  (w_swap)
    );

    assign w_phase_end = phase_q[0] ? (pair_q == ODD_LAST) : (pair_q == EVEN_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        pair_d    = pair_q;
        swp_d     = swp_q;
        w_load_en = 1'b0;
        w_sort_en = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_SORT;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_SORT: begin
                busy      = 1'b1;
                w_sort_en = 1'b1;
                swp_d     = swp_q | w_swap;
                if (w_phase_end) begin
                    pair_d  = '0;
                    phase_d = phase_q + IW'(1);
                    if (phase_q == LAST_PHASE) begin
                        state_d = ST_DRAIN;
                        phase_d = '0;
                    end
                    // An odd phase closes an even+odd pair; a quiet pair means sorted.
                    if (phase_q[0]) begin
                        swp_d = 1'b0;
                        if (EARLY_EXIT && !(swp_q || w_swap)) begin
                            state_d = ST_DRAIN;
                            phase_d = '0;
                        end
                    end
                end else begin
                    pair_d = pair_q + PW'(1);
                end
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem_q[idx_q];
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = '0;
                phase_d = '0;
                pair_d  = '0;
                swp_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            phase_q <= '0;
            pair_q  <= '0;
            swp_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_ELEM); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            pair_q  <= pair_d;
            swp_q   <= swp_d;
            if (w_load_en) begin
                mem_q[idx_q] <= in_data;
            end
            if (w_sort_en && w_swap) begin
                mem_q[w_lo] <= w_a_new;
                mem_q[w_hi] <= w_b_new;
            end
        end
    end

endmodule : cas_sort_seq
`default_nettype wire

// File: doc/cas_sort_seq.md
CAS_SORT_SEQ -- requirements
Module: cas_sort_seq

Interface
REQ-001 SHALL have parameter SNG_WIDTH, default 4, meaning element bit width.
REQ-002 SHALL have parameter NUM_ELEM, default 8, meaning elements per sort job; it SHALL be even and at least 4.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset; it is synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  meaning the input word is valid.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts an input word.
REQ-007 SHALL have port in_data  input  SNG_WIDTH  meaning an unsigned element.
REQ-008 SHALL have port out_valid  output  1  meaning out_data is valid.
REQ-009 SHALL have port out_ready  input  1  meaning the consumer accepts out_data.
REQ-010 SHALL have port out_data  output  SNG_WIDTH  meaning a sorted element.
REQ-011 SHALL have port out_last  output  1  meaning the final element of the job.
REQ-012 SHALL have port busy  output  1  meaning the block is in SORT or DRAIN.

Function
REQ-013 SHALL implement a three-state FSM:
- LOAD: in_ready=1, accepts words.
- SORT: runs the sort.
- DRAIN: out_valid=1, streams results.
REQ-014 SHALL accept a word in LOAD on each cycle with in_valid&&in_ready, storing it at register index 0..NUM_ELEM-1 in arrival order.
REQ-015 SHALL move LOAD->SORT on the cycle after the NUM_ELEM-th word is accepted; in_ready SHALL be 0 from that cycle.
REQ-016 SHALL sort with odd-even transposition using exactly one compare-and-swap instance, one comparison per cycle:
- Even phase: pairs (0,1),(2,3),...
- Odd phase: pairs (1,2),(3,4),...,(N-3,N-2).
- Phases alternate, starting with even.
REQ-017 SHALL order results descending, with the maximum at index 0.
REQ-018 SHALL swap a pair only when lower-index < higher-index (unsigned), so equal values are not swapped.
REQ-019 SHALL write each comparison result back to the register file in the same cycle; the next comparison SHALL see the updated values.
REQ-020 SHALL run NUM_ELEM phases, i.e. (N/2)*(N/2)+(N/2)*(N/2-1) cycles (28 for N=8), then enter DRAIN.
REQ-021 SHALL present index 0 first in DRAIN and advance one index per out_valid&&out_ready.
REQ-022 SHALL hold out_data and out_last stable while out_valid&&!out_ready.
REQ-023 SHALL assert out_last only with index N-1; that element's handshake SHALL return the FSM to LOAD, with in_ready=1 on the next cycle.
REQ-024 SHALL ignore in_valid outside LOAD and ignore out_ready outside DRAIN.
REQ-025 SHALL leave the first out_valid 29 cycles after the last input handshake (N=8, macro absent).

Reset
REQ-026 SHALL, on rst_n=0 at a clock edge in any state (including mid-LOAD, mid-SORT or mid-DRAIN):
- Enter LOAD.
- Clear the load, phase and pair counters and discard partial data.
- Drive out_valid=0, out_last=0, busy=0, out_data=0.
- Drive in_ready=1 from the first edge with rst_n=1.
REQ-027 SHALL clear the element registers to 0 on reset.

Configuration
REQ-028 SHALL support macro CAS_SORT_EARLY_EXIT_EN.
- Defined: a swap flag tracks each consecutive even+odd phase pair; if a completed pair made zero swaps, the FSM enters DRAIN on the next cycle.
- Undefined: the full REQ-020 phase count always runs, and sort latency is data-independent.

Structure
REQ-029 SHALL place the FSM state enum (LOAD, SORT, DRAIN) and the default SNG_WIDTH and NUM_ELEM constants in a shared package, cas_pkg.
REQ-030 SHALL instantiate the existing two-input compare-and-swap sub-module cas, with a_new=max and b_new=min, as the single comparator; no other sub-module.

Verification
REQ-031 Bench SHALL load 3,9,1,15,0,7,7,12 -> outputs 15,12,9,7,7,3,1,0, with out_last on the 8th output, first out_valid 29 cycles after the last input (macro absent).
REQ-032 Bench SHALL load already-descending 15..8 with CAS_SORT_EARLY_EXIT_EN defined -> DRAIN entered after the first even+odd phase pair (7 compare cycles + 1) and data unchanged; macro undefined -> 28 cycles.
REQ-033 Bench SHALL load all-5 -> eight 5s out, with no swap asserted on any comparison.
REQ-034 Bench SHALL hold out_ready=0 for 4 cycles at output index 3 -> out_data and out_last stable, index not advancing, no element lost.
REQ-035 Bench SHALL assert rst_n=0 for one cycle at SORT cycle 10 -> the next cycle has in_ready=1, busy=0 and out_valid=0; a fresh job of 8,7,6,5,4,3,2,1 then sorts correctly.
REQ-036 Bench SHALL drive in_valid=1 continuously through SORT and DRAIN -> no extra words stored, and the next job starts only after out_last is accepted.
